// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined SLL/SRL/SRA/ROR shifter with valid/ready and tag passthrough

module shift_pipe #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 2,
  parameter bit ROT_EN      = 1'b1,
  parameter int TAG_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_data,
  input  logic [$clog2(XLEN)-1:0]  in_amt,
  input  logic [1:0]               in_fn,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int L = $clog2(XLEN);
  localparam int S = PIPE_STAGES;

  localparam logic [1:0] FN_SLL = 2'b00;
  localparam logic [1:0] FN_SRL = 2'b01;
  localparam logic [1:0] FN_ROR = 2'b10;
  localparam logic [1:0] FN_SRA = 2'b11;

  // Stage registers; index s holds the result of stage s.
  logic [S-1:0]     r_v;
  logic [XLEN-1:0]  r_d   [S];
  logic [L-1:0]     r_a   [S];
  logic [1:0]       r_f   [S];
  logic             r_sg  [S];
  logic [TAG_W-1:0] r_t   [S];

  // Inputs seen by each stage (request for stage 0, previous register otherwise).
  logic [S-1:0]     src_v;
  logic [XLEN-1:0]  src_d  [S];
  logic [L-1:0]     src_a  [S];
  logic [1:0]       src_f  [S];
  logic             src_sg [S];
  logic [TAG_W-1:0] src_t  [S];

  // Combinational result of each stage's shift levels.
  logic [XLEN-1:0]  nd [S];

  logic advance;

  // Global stall: the whole pipe moves whenever the output slot is free or being drained.
  assign advance   = !r_v[S-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = r_v[S-1];
  assign out_data  = r_d[S-1];
  assign out_tag   = r_t[S-1];

  // One shift level of 2^k positions. SRA fills from the original sign, not the partial MSB.
  function automatic logic [XLEN-1:0] shift_level(
    input logic [XLEN-1:0] x,
    input logic            en,
    input int              k,
    input logic [1:0]      fn,
    input logic            sgn
  );
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] fill;
    int              sh;
    sh   = 1 << k;
    fill = sgn ? ~({XLEN{1'b1}} >> sh) : '0;
    r    = x;
    if (fn == FN_ROR && !ROT_EN) begin
      // Rotate disabled: the result is forced to zero regardless of amount.
      r = '0;
    end else if (en) begin
      case (fn)
        FN_SLL:  r = x << sh;
        FN_SRL:  r = x >> sh;
        FN_SRA:  r = (x >> sh) | fill;
        default: r = (x >> sh) | (x << (XLEN - sh));
      endcase
    end
    return r;
  endfunction

  // Apply all levels mapped to stage s; level i uses amount bit L-1-i (MSB first).
  function automatic logic [XLEN-1:0] stage_eval(
    input int              s,
    input logic [XLEN-1:0] x,
    input logic [L-1:0]    amt,
    input logic [1:0]      fn,
    input logic            sgn
  );
    logic [XLEN-1:0] r;
    r = x;
    for (int i = 0; i < L; i++) begin
      if ((i * S) / L == s) begin
        r = shift_level(r, amt[L-1-i], L - 1 - i, fn, sgn);
      end
    end
    return r;
  endfunction

  // Route the request into stage 0 and each register into the following stage.
  always_comb begin
    src_v[0]  = in_valid;
    src_d[0]  = in_data;
    src_a[0]  = in_amt;
    src_f[0]  = in_fn;
    src_sg[0] = in_data[XLEN-1];
    src_t[0]  = in_tag;
    for (int s = 1; s < S; s++) begin
      src_v[s]  = r_v[s-1];
      src_d[s]  = r_d[s-1];
      src_a[s]  = r_a[s-1];
      src_f[s]  = r_f[s-1];
      src_sg[s] = r_sg[s-1];
      src_t[s]  = r_t[s-1];
    end
  end

  // Shift-level datapath for every stage.
  always_comb begin
    for (int s = 0; s < S; s++) begin
      nd[s] = stage_eval(s, src_d[s], src_a[s], src_f[s], src_sg[s]);
    end
  end

  // Pipeline registers: reset clears everything, flush kills valids, otherwise shift on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int s = 0; s < S; s++) begin
        r_d[s]  <= '0;
        r_a[s]  <= '0;
        r_f[s]  <= '0;
        r_sg[s] <= 1'b0;
        r_t[s]  <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else if (advance) begin
      r_v <= src_v;
      for (int s = 0; s < S; s++) begin
        r_d[s]  <= nd[s];
        r_a[s]  <= src_a[s];
        r_f[s]  <= src_f[s];
        r_sg[s] <= src_sg[s];
        r_t[s]  <= src_t[s];
      end
    end
  end

endmodule
